// File: rtl/tcp_rx_buf_responder.sv
// rtl/tcp_rx_buf_responder.sv - TCP RX buffer request/adjust responder with per-flow head indices
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 256
`endif

package tcp_rx_buf_pkg;
    localparam int MAX_FLOWID_W      = 3;
    localparam int MAX_PAYLOAD_IDX_W = 3;
    localparam int TCP_BUF_PTR_W     = 32;
    localparam int TCP_BUF_LEN_W     = 32;
    localparam int TCP_BUF_CAP_W     = 33;
    localparam int TCP_BUF_W         = TCP_BUF_PTR_W + TCP_BUF_LEN_W + TCP_BUF_CAP_W;
    localparam int NOC_HDR_W         = 56;
    localparam logic [7:0] TCP_RX_BUF_IF_X     = 8'd1;
    localparam logic [7:0] TCP_RX_BUF_IF_Y     = 8'd2;
    localparam logic [3:0] TCP_RX_BUF_IF_FBITS = 4'hA;
endpackage

module tcp_rx_buf_responder
    import tcp_rx_buf_pkg::*;
#(
    parameter int         NOC_DATA_W      = `NOC_DATA_WIDTH,
    parameter int         FLOWID_W        = MAX_FLOWID_W,
    parameter logic [7:0] MSG_TYPE_REQ    = 8'd1,
    parameter logic [7:0] MSG_TYPE_ADJUST = 8'd2,
    parameter logic [7:0] MSG_TYPE_RESP   = 8'd3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         noc_in_val,
    input  logic [NOC_DATA_W-1:0]        noc_in_data,
    output logic                         noc_in_rdy,
    output logic                         noc_out_val,
    output logic [NOC_DATA_W-1:0]        noc_out_data,
    input  logic                         noc_out_rdy,
    output logic                         desc_rd_req_val,
    output logic [FLOWID_W-1:0]          desc_rd_req_flowid,
    output logic [MAX_PAYLOAD_IDX_W-1:0] desc_rd_req_idx,
    input  logic                         desc_rd_req_rdy,
    input  logic                         desc_rd_resp_val,
    input  logic [TCP_BUF_W-1:0]         desc_rd_resp_data,
    input  logic                         flow_init_val,
    input  logic [FLOWID_W-1:0]          flow_init_flowid,
    output logic [15:0]                  adjust_err_cnt
);

    localparam int HEAD_W     = MAX_PAYLOAD_IDX_W + 1;
    localparam int NUM_FLOWS  = 2 ** FLOWID_W;
    localparam int FLOWID_LSB = NOC_DATA_W - NOC_HDR_W - FLOWID_W;
    localparam int BUF_LSB    = FLOWID_LSB - TCP_BUF_W;
    localparam int IDX_LSB    = BUF_LSB - HEAD_W;
    localparam int PAD_W      = IDX_LSB;

    typedef enum logic [2:0] {
        RX_HDR,
        DESC_REQ,
        DESC_WAIT,
        TX_RESP,
        ADJUST
    } state_t;

    state_t state_q, state_d;

    logic [7:0]           req_src_x_q;
    logic [7:0]           req_src_y_q;
    logic [3:0]           req_src_fbits_q;
    logic [FLOWID_W-1:0]  req_flowid_q;
    logic [HEAD_W-1:0]    adj_idx_q;
    logic [HEAD_W-1:0]    resp_idx_q;
    logic [TCP_BUF_W-1:0] desc_q;
    logic [HEAD_W-1:0]    head_q [NUM_FLOWS];
    logic [15:0]          err_cnt_q;

    logic [7:0]        in_msg_type;
    logic              in_hs;
    logic [HEAD_W-1:0] cur_head;
    logic              adj_inc;
    logic              adj_err;
    logic              unused_in_bits;

    assign in_msg_type = noc_in_data[NOC_DATA_W-49 -: 8];
    assign in_hs       = noc_in_val && noc_in_rdy;
    assign cur_head    = head_q[req_flowid_q];
    assign adj_inc     = (state_q == ADJUST) && (adj_idx_q == cur_head);
    assign adj_err     = (state_q == ADJUST) && (adj_idx_q != cur_head);

    // Destination, msg_len, the request length/old buffer body and padding are never consulted.
    assign unused_in_bits = ^{noc_in_data[NOC_DATA_W-1 -: 20],
                              noc_in_data[NOC_DATA_W-41 -: 8],
                              noc_in_data[BUF_LSB +: TCP_BUF_W],
                              noc_in_data[PAD_W-1:0]};

    always_comb begin
        state_d         = state_q;
        noc_in_rdy      = 1'b0;
        desc_rd_req_val = 1'b0;
        noc_out_val     = 1'b0;
        case (state_q)
            RX_HDR: begin
                noc_in_rdy = rst_n;
                if (noc_in_val) begin
                    if (in_msg_type == MSG_TYPE_REQ) begin
                        state_d = DESC_REQ;
                    end else if (in_msg_type == MSG_TYPE_ADJUST) begin
                        state_d = ADJUST;
                    end
                end
            end
            DESC_REQ: begin
                desc_rd_req_val = rst_n;
                if (desc_rd_req_rdy) begin
                    state_d = DESC_WAIT;
                end
            end
            DESC_WAIT: begin
                if (desc_rd_resp_val) begin
                    state_d = TX_RESP;
                end
            end
            TX_RESP: begin
                noc_out_val = rst_n;
                if (noc_out_rdy) begin
                    state_d = RX_HDR;
                end
            end
            ADJUST: begin
                state_d = RX_HDR;
            end
            default: begin
                state_d = RX_HDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= RX_HDR;
            req_src_x_q     <= '0;
            req_src_y_q     <= '0;
            req_src_fbits_q <= '0;
            req_flowid_q    <= '0;
            adj_idx_q       <= '0;
            resp_idx_q      <= '0;
            desc_q          <= '0;
            err_cnt_q       <= '0;
            for (int i = 0; i < NUM_FLOWS; i++) begin
                head_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (in_hs) begin
                req_src_x_q     <= noc_in_data[NOC_DATA_W-21 -: 8];
                req_src_y_q     <= noc_in_data[NOC_DATA_W-29 -: 8];
                req_src_fbits_q <= noc_in_data[NOC_DATA_W-37 -: 4];
                req_flowid_q    <= noc_in_data[FLOWID_LSB +: FLOWID_W];
                adj_idx_q       <= noc_in_data[IDX_LSB +: HEAD_W];
            end
            // Snapshot the head on acceptance so a later flow_init cannot disturb the reply.
            if (state_q == DESC_REQ && desc_rd_req_rdy) begin
                resp_idx_q <= cur_head;
            end
            if (state_q == DESC_WAIT && desc_rd_resp_val) begin
                desc_q <= desc_rd_resp_data;
            end
            for (int i = 0; i < NUM_FLOWS; i++) begin
                if (flow_init_val && flow_init_flowid == FLOWID_W'(i)) begin
                    head_q[i] <= '0;
                end else if (adj_inc && req_flowid_q == FLOWID_W'(i)) begin
                    head_q[i] <= head_q[i] + HEAD_W'(1);
                end
            end
            if (adj_err && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign desc_rd_req_flowid = req_flowid_q;
    assign desc_rd_req_idx    = cur_head[MAX_PAYLOAD_IDX_W-1:0];
    assign adjust_err_cnt     = err_cnt_q;

    assign noc_out_data = {req_src_x_q, req_src_y_q, req_src_fbits_q,
                           TCP_RX_BUF_IF_X, TCP_RX_BUF_IF_Y, TCP_RX_BUF_IF_FBITS,
                           8'd0, MSG_TYPE_RESP,
                           req_flowid_q, desc_q, resp_idx_q,
                           {PAD_W{1'b0}}};

endmodule

// File: tb/tb_tcp_rx_buf_responder.sv
// tb/tb_tcp_rx_buf_responder.sv - self-checking bench for tcp_rx_buf_responder
module tb_tcp_rx_buf_responder;
    import tcp_rx_buf_pkg::*;

    localparam int DW   = `NOC_DATA_WIDTH;
    localparam int FW   = MAX_FLOWID_W;
    localparam int IW   = MAX_PAYLOAD_IDX_W;
    localparam int HW   = IW + 1;
    localparam int PADW = DW - NOC_HDR_W - FW - TCP_BUF_W - HW;
    localparam logic [7:0] T_REQ  = 8'd1;
    localparam logic [7:0] T_ADJ  = 8'd2;
    localparam logic [7:0] T_RESP = 8'd3;

    localparam int OP_REQ = 0;
    localparam int OP_ADJ = 1;
    localparam int OP_OTH = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 noc_in_val;
    logic [DW-1:0]        noc_in_data;
    logic                 noc_in_rdy;
    logic                 noc_out_val;
    logic [DW-1:0]        noc_out_data;
    logic                 noc_out_rdy;
    logic                 desc_rd_req_val;
    logic [FW-1:0]        desc_rd_req_flowid;
    logic [IW-1:0]        desc_rd_req_idx;
    logic                 desc_rd_req_rdy;
    logic                 desc_rd_resp_val;
    logic [TCP_BUF_W-1:0] desc_rd_resp_data;
    logic                 flow_init_val;
    logic [FW-1:0]        flow_init_flowid;
    logic [15:0]          adjust_err_cnt;

    tcp_rx_buf_responder #(
        .NOC_DATA_W      (DW),
        .FLOWID_W        (FW),
        .MSG_TYPE_REQ    (T_REQ),
        .MSG_TYPE_ADJUST (T_ADJ),
        .MSG_TYPE_RESP   (T_RESP)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .noc_in_val         (noc_in_val),
        .noc_in_data        (noc_in_data),
        .noc_in_rdy         (noc_in_rdy),
        .noc_out_val        (noc_out_val),
        .noc_out_data       (noc_out_data),
        .noc_out_rdy        (noc_out_rdy),
        .desc_rd_req_val    (desc_rd_req_val),
        .desc_rd_req_flowid (desc_rd_req_flowid),
        .desc_rd_req_idx    (desc_rd_req_idx),
        .desc_rd_req_rdy    (desc_rd_req_rdy),
        .desc_rd_resp_val   (desc_rd_resp_val),
        .desc_rd_resp_data  (desc_rd_resp_data),
        .flow_init_val      (flow_init_val),
        .flow_init_flowid   (flow_init_flowid),
        .adjust_err_cnt     (adjust_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int mem_delay = 1;

    typedef struct {
        logic [FW-1:0]        fid;
        logic [IW-1:0]        idx;
        logic [TCP_BUF_W-1:0] data;
    } desc_t;

    typedef struct {
        int                   op;
        logic [FW-1:0]        fid;
        logic [HW-1:0]        old_idx;
        logic [TCP_BUF_W-1:0] desc;
        logic [IW-1:0]        exp_desc_idx;
        logic [HW-1:0]        exp_resp_idx;
        logic [15:0]          exp_err;
    } vec_t;

    logic [DW-1:0] resp_q [$];
    desc_t         desc_q [$];
    vec_t          tbl [9];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [TCP_BUF_W-1:0] mk_desc(input logic [31:0] ptr, input logic [31:0] len,
                                                     input logic [32:0] cap);
        return {ptr, len, cap};
    endfunction

    function automatic logic [TCP_BUF_W-1:0] junk();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[TCP_BUF_W-1:0];
    endfunction

    function automatic logic [DW-1:0] mk_in(input logic [7:0] typ, input logic [7:0] sx, input logic [7:0] sy,
                                            input logic [3:0] sf, input logic [FW-1:0] fid,
                                            input logic [TCP_BUF_W-1:0] body, input logic [HW-1:0] idx);
        return {TCP_RX_BUF_IF_X, TCP_RX_BUF_IF_Y, TCP_RX_BUF_IF_FBITS, sx, sy, sf, 8'd0, typ,
                fid, body, idx, {PADW{1'b0}}};
    endfunction

    function automatic logic [DW-1:0] mk_resp(input logic [7:0] sx, input logic [7:0] sy, input logic [3:0] sf,
                                              input logic [FW-1:0] fid, input logic [TCP_BUF_W-1:0] desc,
                                              input logic [HW-1:0] idx);
        return {sx, sy, sf, TCP_RX_BUF_IF_X, TCP_RX_BUF_IF_Y, TCP_RX_BUF_IF_FBITS, 8'd0, T_RESP,
                fid, desc, idx, {PADW{1'b0}}};
    endfunction

    // Outbound monitor: every accepted response must match the head of the scoreboard.
    initial begin
        logic [DW-1:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n && noc_out_val && noc_out_rdy) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flit: actual=%0h required=none", noc_out_data);
                end else begin
                    exp = resp_q.pop_front();
                    check("resp_flit", noc_out_data, exp);
                end
            end
        end
    end

    // Descriptor memory model with a programmable read latency.
    initial begin
        desc_t d;
        desc_rd_resp_val  = 1'b0;
        desc_rd_resp_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n && desc_rd_req_val && desc_rd_req_rdy) begin
                if (desc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_desc_req: actual=%0h required=none", desc_rd_req_idx);
                    d.data = '0;
                end else begin
                    d = desc_q.pop_front();
                    check("desc_flowid", DW'(desc_rd_req_flowid), DW'(d.fid));
                    check("desc_idx", DW'(desc_rd_req_idx), DW'(d.idx));
                end
                @(posedge clk);
                repeat (mem_delay - 1) @(posedge clk);
                #1;
                desc_rd_resp_val  = 1'b1;
                desc_rd_resp_data = d.data;
                @(posedge clk);
                #1;
                desc_rd_resp_val  = 1'b0;
                desc_rd_resp_data = '0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [DW-1:0] f);
        int n;
        n = 0;
        noc_in_val  = 1'b1;
        noc_in_data = f;
        @(negedge clk);
        while (!noc_in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!noc_in_rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual=%0d cycles required=accept", n);
        end
        @(posedge clk);
        #1;
        noc_in_val = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || desc_q.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", DW'(resp_q.size() + desc_q.size()), DW'(0));
    endtask

    task automatic do_req(input logic [7:0] sx, input logic [7:0] sy, input logic [3:0] sf,
                          input logic [FW-1:0] fid, input logic [IW-1:0] exp_didx,
                          input logic [HW-1:0] exp_ridx, input logic [TCP_BUF_W-1:0] desc);
        desc_t d;
        d.fid  = fid;
        d.idx  = exp_didx;
        d.data = desc;
        desc_q.push_back(d);
        resp_q.push_back(mk_resp(sx, sy, sf, fid, desc, exp_ridx));
        send(mk_in(T_REQ, sx, sy, sf, fid, junk(), HW'($urandom_range(0, 15))));
        wait_drain();
    endtask

    task automatic do_adj(input logic [FW-1:0] fid, input logic [HW-1:0] old_idx);
        send(mk_in(T_ADJ, 8'h10, 8'h20, 4'h1, fid, junk(), old_idx));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        logic [DW-1:0] exp_flit;
        desc_t d;

        tbl[0] = '{OP_REQ, 3'd3, 4'd0, mk_desc(32'h1000, 32'h0, 33'h800), 3'd0, 4'd0, 16'd0};
        tbl[1] = '{OP_ADJ, 3'd3, 4'd0, '0, 3'd0, 4'd0, 16'd0};
        tbl[2] = '{OP_REQ, 3'd3, 4'd0, mk_desc(32'h2000, 32'h10, 33'h800), 3'd1, 4'd1, 16'd0};
        tbl[3] = '{OP_ADJ, 3'd2, 4'd3, '0, 3'd0, 4'd0, 16'd1};
        tbl[4] = '{OP_OTH, 3'd1, 4'd0, '0, 3'd0, 4'd0, 16'd1};
        tbl[5] = '{OP_REQ, 3'd2, 4'd0, mk_desc(32'h3000, 32'h4, 33'h400), 3'd0, 4'd0, 16'd1};
        tbl[6] = '{OP_ADJ, 3'd3, 4'd0, '0, 3'd0, 4'd0, 16'd2};
        tbl[7] = '{OP_ADJ, 3'd3, 4'd1, '0, 3'd0, 4'd0, 16'd2};
        tbl[8] = '{OP_REQ, 3'd3, 4'd0, mk_desc(32'h4000, 32'h0, 33'h1_0000_0000), 3'd2, 4'd2, 16'd2};

        rst_n            = 1'b0;
        noc_in_val       = 1'b0;
        noc_in_data      = '0;
        noc_out_rdy      = 1'b1;
        desc_rd_req_rdy  = 1'b1;
        flow_init_val    = 1'b0;
        flow_init_flowid = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy", DW'(noc_in_rdy), DW'(0));
        check("rst_out_val", DW'(noc_out_val), DW'(0));
        check("rst_req_val", DW'(desc_rd_req_val), DW'(0));
        check("rst_err_cnt", DW'(adjust_err_cnt), DW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_rdy", DW'(noc_in_rdy), DW'(1));
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            case (tbl[i].op)
                OP_REQ: do_req(8'(i + 1), 8'(i + 4), 4'(i), tbl[i].fid, tbl[i].exp_desc_idx,
                               tbl[i].exp_resp_idx, tbl[i].desc);
                OP_ADJ: do_adj(tbl[i].fid, tbl[i].old_idx);
                default: begin
                    send(mk_in(8'h09, 8'h11, 8'h22, 4'h3, tbl[i].fid, junk(), 4'd0));
                    repeat (2) @(posedge clk);
                    #1;
                end
            endcase
            check($sformatf("err_cnt_row%0d", i), DW'(adjust_err_cnt), DW'(tbl[i].exp_err));
        end

        // Flow 5 walks its head through the full 4-bit range and wraps.
        for (int k = 0; k < 9; k++) do_adj(3'd5, 4'(k));
        do_req(8'h31, 8'h32, 4'h5, 3'd5, 3'd1, 4'b1001, mk_desc(32'h5000, 32'h1, 33'h80));
        for (int k = 9; k < 16; k++) do_adj(3'd5, 4'(k));
        do_req(8'h33, 8'h34, 4'h6, 3'd5, 3'd0, 4'd0, mk_desc(32'h6000, 32'h2, 33'h80));
        check("err_after_wrap", DW'(adjust_err_cnt), DW'(2));

        // Backpressure on the response, with a flow_init on the in-flight flow.
        noc_out_rdy = 1'b0;
        d.fid  = 3'd3;
        d.idx  = 3'd2;
        d.data = mk_desc(32'h7000, 32'h3, 33'h200);
        desc_q.push_back(d);
        exp_flit = mk_resp(8'h41, 8'h42, 4'h7, 3'd3, d.data, 4'd2);
        resp_q.push_back(exp_flit);
        send(mk_in(T_REQ, 8'h41, 8'h42, 4'h7, 3'd3, junk(), 4'd0));
        lat = 0;
        @(negedge clk);
        while (!noc_out_val && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        for (int c = 0; c < 5; c++) begin
            check("bp_out_val", DW'(noc_out_val), DW'(1));
            check("bp_data", noc_out_data, exp_flit);
            check("bp_in_rdy", DW'(noc_in_rdy), DW'(0));
            @(posedge clk);
            #1;
            if (c == 0) begin
                noc_in_val  = 1'b1;
                noc_in_data = mk_in(T_ADJ, 8'h10, 8'h20, 4'h1, 3'd3, junk(), 4'd0);
            end
            if (c == 1) begin
                flow_init_val    = 1'b1;
                flow_init_flowid = 3'd3;
            end
            if (c == 2) flow_init_val = 1'b0;
            if (c == 4) noc_out_rdy = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("in_rdy_after_resp", DW'(noc_in_rdy), DW'(1));
        @(posedge clk);
        #1;
        noc_in_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("err_after_bp_adj", DW'(adjust_err_cnt), DW'(2));
        do_req(8'h43, 8'h44, 4'h8, 3'd3, 3'd1, 4'd1, mk_desc(32'h8000, 32'h0, 33'h100));

        // flow_init and a matching adjust collide on flow 7.
        do_adj(3'd7, 4'd0);
        do_adj(3'd7, 4'd1);
        send(mk_in(T_ADJ, 8'h10, 8'h20, 4'h1, 3'd7, junk(), 4'd2));
        flow_init_val    = 1'b1;
        flow_init_flowid = 3'd7;
        @(posedge clk);
        #1;
        flow_init_val = 1'b0;
        @(posedge clk);
        #1;
        check("init_vs_adj_err", DW'(adjust_err_cnt), DW'(2));
        do_req(8'h51, 8'h52, 4'h9, 3'd7, 3'd0, 4'd0, mk_desc(32'h9000, 32'h5, 33'h40));

        // Inbound handshake cycle counts as cycle 1; the response must be valid in cycle 4.
        d.fid  = 3'd1;
        d.idx  = 3'd0;
        d.data = mk_desc(32'hA000, 32'h6, 33'h20);
        desc_q.push_back(d);
        resp_q.push_back(mk_resp(8'h61, 8'h62, 4'hB, 3'd1, d.data, 4'd0));
        noc_in_val  = 1'b1;
        noc_in_data = mk_in(T_REQ, 8'h61, 8'h62, 4'hB, 3'd1, junk(), 4'd0);
        @(negedge clk);
        check("lat_in_rdy", DW'(noc_in_rdy), DW'(1));
        @(posedge clk);
        #1;
        noc_in_val = 1'b0;
        lat = 1;
        do begin
            @(negedge clk);
            lat++;
        end while (!noc_out_val && lat < 20);
        check("latency", DW'(lat), DW'(4));
        wait_drain();

        // Reset while waiting on the descriptor; the late read data must be ignored.
        mem_delay = 4;
        d.fid  = 3'd3;
        d.idx  = 3'd1;
        d.data = mk_desc(32'hB000, 32'h7, 33'h10);
        desc_q.push_back(d);
        send(mk_in(T_REQ, 8'h71, 8'h72, 4'hC, 3'd3, junk(), 4'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_in_rdy", DW'(noc_in_rdy), DW'(0));
        check("mid_rst_req_val", DW'(desc_rd_req_val), DW'(0));
        check("mid_rst_out_val", DW'(noc_out_val), DW'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_err_cnt", DW'(adjust_err_cnt), DW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_release_in_rdy", DW'(noc_in_rdy), DW'(1));
        repeat (8) @(posedge clk);
        #1;
        mem_delay = 1;
        check("stale_resp_out_val", DW'(noc_out_val), DW'(0));
        do_req(8'h73, 8'h74, 4'hD, 3'd3, 3'd0, 4'd0, mk_desc(32'hC000, 32'h8, 33'h8));
        check("final_err_cnt", DW'(adjust_err_cnt), DW'(0));

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcp_rx_buf_responder.md
TCP_RX_BUF_RESPONDER -- requirements
Module: tcp_rx_buf_responder

Interface
REQ-001 SHALL have parameter NOC_DATA_W, default `NOC_DATA_WIDTH, meaning NoC flit width.
REQ-002 SHALL have parameter FLOWID_W, default MAX_FLOWID_W, meaning flow ID width; the number of flows is 2**FLOWID_W.
REQ-003 SHALL have parameter MSG_TYPE_REQ, default 8'd1, meaning the header msg_type that carries tcp_msg_req.
REQ-004 SHALL have parameter MSG_TYPE_ADJUST, default 8'd2, meaning the header msg_type that carries tcp_adjust_idx.
REQ-005 SHALL have parameter MSG_TYPE_RESP, default 8'd3, meaning the header msg_type that carries tcp_msg_resp.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 noc_in_val / noc_in_data / noc_in_rdy  in/in/out  1/NOC_DATA_W/1  inbound single-flit tcp_noc_hdr_flit messages.
REQ-009 noc_out_val / noc_out_data / noc_out_rdy  out/out/in  1/NOC_DATA_W/1  outbound single-flit response.
REQ-010 desc_rd_req_val / desc_rd_req_flowid / desc_rd_req_idx / desc_rd_req_rdy  out/out/out/in  1/FLOWID_W/MAX_PAYLOAD_IDX_W/1  descriptor memory read request.
REQ-011 desc_rd_resp_val / desc_rd_resp_data  in/in  1/TCP_BUF_W  descriptor read data (tcp_buf); arrives one or more cycles after the request is accepted.
REQ-012 flow_init_val / flow_init_flowid  in/in  1/FLOWID_W  clears the head index of a flow.
REQ-013 adjust_err_cnt  out  16  saturating count of rejected adjust messages.

Function
REQ-014 SHALL hold a head index per flow, MAX_PAYLOAD_IDX_W+1 bits wide, with the top bit acting as the wrap bit.
REQ-015 The FSM SHALL have exactly these states: RX_HDR, DESC_REQ, DESC_WAIT, TX_RESP, ADJUST.
REQ-016 In RX_HDR, noc_in_rdy SHALL be 1; all other states SHALL drive noc_in_rdy = 0.
REQ-017 In RX_HDR, on a handshake the block SHALL latch the flit.
REQ-018 After latching a flit in RX_HDR, the next state SHALL be:
- DESC_REQ if msg_type = MSG_TYPE_REQ;
- ADJUST if msg_type = MSG_TYPE_ADJUST;
- RX_HDR otherwise (flit dropped).
REQ-019 In DESC_REQ, desc_rd_req_val SHALL be 1, with flowid taken from the latched flit and idx = head[MAX_PAYLOAD_IDX_W-1:0]; on desc_rd_req_rdy the FSM SHALL move to DESC_WAIT.
REQ-020 In DESC_WAIT, on desc_rd_resp_val the block SHALL latch the descriptor and move to TX_RESP.
REQ-021 In TX_RESP, noc_out_val SHALL be 1, and the response flit SHALL carry:
- dst_x/dst_y/dst_fbits = request src_x/src_y/src_fbits;
- src fields = own coordinates with src_fbits = TCP_RX_BUF_IF_FBITS;
- msg_len = 0;
- msg_type = MSG_TYPE_RESP;
- inner.flowid = request flowid;
- resp_buf.buf_info = latched descriptor;
- resp_buf.idx = head sampled in DESC_REQ;
- padding = 0.
REQ-022 noc_out_data SHALL be held stable while noc_out_val=1 and noc_out_rdy=0; on handshake the FSM SHALL return to RX_HDR.
REQ-023 A request SHALL NOT modify the head; the tcp_msg_req __length field SHALL be ignored.
REQ-024 In ADJUST, a single cycle: if old_buf.idx equals the flow's head, head SHALL become head+1 modulo 2**(MAX_PAYLOAD_IDX_W+1); otherwise head SHALL be unchanged and adjust_err_cnt SHALL increment, saturating at 16'hFFFF.
REQ-025 ADJUST SHALL produce no outbound flit; the next state SHALL be RX_HDR.
REQ-026 flow_init_val SHALL set the selected head to 0 at the next edge in any state.
REQ-027 When flow_init and an ADJUST increment target the same flow in the same cycle, the init SHALL win.
REQ-028 A flow_init on the flow currently in DESC_REQ/DESC_WAIT/TX_RESP SHALL NOT alter that in-flight response's idx.
REQ-029 Latency from inbound handshake to noc_out_val, with desc_rd_req_rdy=1 and 1-cycle read data, SHALL be 4 cycles.
REQ-030 The block SHALL have no request queue: one message in flight at a time.

Reset
REQ-031 While rst_n=0 at a clock edge:
- FSM SHALL go to RX_HDR;
- all heads SHALL be 0;
- adjust_err_cnt SHALL be 0;
- noc_out_val, desc_rd_req_val and noc_in_rdy SHALL be 0 during reset.
REQ-032 Reset asserted mid-operation SHALL abandon the in-flight message with no output flit; a desc_rd_resp_val arriving after reset SHALL be ignored unless in DESC_WAIT.
REQ-033 noc_in_rdy SHALL be 1 in the first cycle after rst_n rises.

Verification
REQ-034 Request flow 3 after reset, descriptor {ptr=32'h1000, len=0, cap=33'h800} -> desc idx 0; response resp_buf.idx=0, buf_info matches, dst = request src.
REQ-035 Adjust flow 3 with old idx 0, then request flow 3 -> desc_rd_req_idx=1, resp idx=1; adjust_err_cnt=0.
REQ-036 16 matching adjusts on flow 5 -> head 0..15, then wraps to 0; after 9 adjusts the desc idx = 1 and resp idx = 4'b1001.
REQ-037 Adjust flow 2 with old idx 3 while head=0 -> head stays 0, adjust_err_cnt=1, no outbound flit.
REQ-038 Hold noc_out_rdy=0 for 5 cycles during TX_RESP -> noc_out_data constant, noc_in_rdy=0; a flit is accepted the cycle after the handshake.
REQ-039 flow_init on flow 7 in the same cycle as a matching ADJUST on flow 7 with head=2 -> head=0, adjust_err_cnt unchanged.
